bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (IF, driven by the PC register) and
//  data access (MEM stage). Grants one transaction at a time, MEM over IF.
//  Raises stall requests to the pipeline control module until each stage's data is returned.
//  Holds returned data stable until the owning stage advances.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles bus_req may wait for bus_ack before abort; 0 = never abort
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   reset, synchronous, active-high
//  stall         in   6   pipeline stall vector, bit0 PC..bit5 WB; 0 = stage advances
//  flush         in   1   pipeline flush (exception); 1-cycle pulse
//  if_ce         in   1   IF wants an instruction
//  if_addr       in   32  fetch address (= pc)
//  if_rdata      out  32  fetched instruction
//  mem_ce        in   1   MEM stage wants a data access
//  mem_we        in   1   1 = store, 0 = load
//  mem_sel       in   4   byte enables
//  mem_addr      in   32  data address
//  mem_wdata     in   32  store data
//  mem_rdata     out  32  load data
//  stallreq_if   out  1   IF result not yet available
//  stallreq_mem  out  1   MEM result not yet available
//  bus_req       out  1   transaction request, held until ack/abort
//  bus_we/bus_sel/bus_addr/bus_wdata  out 1/4/32/32  registered transaction fields
//  bus_rdata     in   32  read data, valid with bus_ack
//  bus_ack       in   1   slave completion, 1 cycle
//  bus_err       out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: state IDLE; bus_req, bus_we, bus_err, stallreq_* (regs) 0; bus_sel 0; bus_addr, bus_wdata,
//    if_rdata, mem_rdata 32'h0; if_done, mem_done 0; timeout counter 0. Reset mid-transaction drops
//    bus_req at that edge; a late ack is ignored.
//  - FSM: IDLE -> MEM_BUSY or IF_BUSY -> IDLE. Single outstanding transaction.
//  - IDLE issue: at edge where mem_ce & !mem_done -> MEM_BUSY, bus fields latched from mem_*;
//    else if if_ce & !if_done -> IF_BUSY, bus_we=0, bus_sel=4'hF, bus_addr=if_addr. bus_req=1 from
//    next cycle. MEM wins simultaneous requests.
//  - Completion: edge with bus_req & bus_ack -> capture bus_rdata into if_rdata/mem_rdata (stores:
//    mem_rdata unchanged), set matching *_done, bus_req=0, back to IDLE. Min latency request->data: 2 cycles.
//  - Timeout: counter increments each cycle bus_req=1 & !bus_ack; on reaching ACK_TIMEOUT -> bus_req=0,
//    bus_err=1 for one cycle, *_done=1, rdata=32'h0, IDLE. Counter clears on every issue.
//  - stallreq_if = if_ce & !if_done; stallreq_mem = mem_ce & !mem_done (combinational from regs).
//  - Done clear: if_done cleared at edge with stall[1]==0; mem_done at edge with stall[4]==0;
//    rdata outputs keep value until next capture.
//  - Back-to-back: IDLE may re-issue at the same edge a done flag clears; no bubble required beyond IDLE.
//  - flush: clears if_done, mem_done; an in-flight transaction still completes on the bus (no abort)
//    but its data is discarded and no done flag set; pending un-issued requests abandoned.
//  - flush and ack same edge: flush wins (data discarded).
//  - IF request address change while IF_BUSY is ignored; latched bus_addr used.
// TESTING
//  1 IF only, ack 1 cycle after bus_req, if_addr=0x0 -> bus_addr=0, if_rdata=ack data, stallreq_if 1 for 2 cycles.
//  2 mem_ce & if_ce same cycle, load 0x100 -> MEM issued first, IF issued the cycle after MEM ack.
//  3 store sel=4'b0011 addr 0x20 wdata 0xDEADBEEF -> bus fields match, mem_rdata unchanged, stallreq_mem drops.
//  4 ACK_TIMEOUT=4, no ack -> bus_req high 4 cycles, bus_err pulse, rdata 0, stallreq cleared.
//  5 flush during IF_BUSY, ack arrives next cycle -> if_done stays 0, if_rdata unchanged, new fetch issued.
//  6 rst asserted mid MEM_BUSY -> bus_req 0 next cycle; late ack causes no capture.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Pipeline-side and memory-bus-side signals of the IF/MEM bus arbiter.
// The arbiter uses the master modport; the pipeline/bus environment uses the slave modport.
interface bus_arbiter_if;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    input  stall, flush,
    input  if_ce, if_addr,
    output if_rdata,
    input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata,
    output stallreq_if, stallreq_mem,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport slave (
    output stall, flush,
    output if_ce, if_addr,
    input  if_rdata,
    output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata,
    input  stallreq_if, stallreq_mem,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage (MEM has priority),
// stalls each stage until its data returns and holds returned data until the stage advances.
module bus_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  bus_arbiter_if.master  bif
);

  localparam int unsigned   CW          = (ACK_TIMEOUT > 32'd1) ? $clog2(ACK_TIMEOUT + 32'd1) : 1;
  localparam logic          TO_EN       = (ACK_TIMEOUT != 32'd0);
  localparam logic [CW-1:0] CNT_LAST    = TO_EN ? CW'(ACK_TIMEOUT - 32'd1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_BUSY = 2'd1,
    ST_IF_BUSY  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_err;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_done;
  logic        r_mem_done;
  logic        r_discard;
  logic [CW-1:0] r_cnt;

  logic        w_issue_mem;
  logic        w_issue_if;
  logic        w_finish;
  logic        w_ack_hit;
  logic        w_expire;
  logic        w_deliver;
  logic [31:0] w_ret_data;
  logic        w_stall_unused;

  assign w_stall_unused = ^{bif.stall[5], bif.stall[3:2], bif.stall[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A finishing transaction delivers nothing if a flush hit it earlier or hits it now.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_mem = 1'b0;
    w_issue_if  = 1'b0;
    w_finish    = 1'b0;
    w_ack_hit   = r_bus_req & bif.bus_ack;
    w_expire    = TO_EN & r_bus_req & ~bif.bus_ack & (r_cnt == CNT_LAST);
    case (r_state)
      ST_IDLE: begin
        if (!bif.flush && bif.mem_ce && !r_mem_done) begin
          w_issue_mem = 1'b1;
          w_state_nxt = ST_MEM_BUSY;
        end else if (!bif.flush && bif.if_ce && !r_if_done) begin
          w_issue_if  = 1'b1;
          w_state_nxt = ST_IF_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEM_BUSY, ST_IF_BUSY: begin
        if (w_ack_hit || w_expire) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_deliver  = w_finish & ~r_discard & ~bif.flush;
    w_ret_data = w_ack_hit ? bif.bus_rdata : 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_wdata <= 32'h0000_0000;
      r_bus_err   <= 1'b0;
      r_cnt       <= {CW{1'b0}};
    end else begin
      r_bus_err <= 1'b0;
      if (w_issue_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= bif.mem_we;
        r_bus_sel   <= bif.mem_sel;
        r_bus_addr  <= bif.mem_addr;
        r_bus_wdata <= bif.mem_wdata;
        r_cnt       <= {CW{1'b0}};
      end else if (w_issue_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_sel   <= 4'hF;
        r_bus_addr  <= bif.if_addr;
        r_cnt       <= {CW{1'b0}};
      end else if (w_finish) begin
        r_bus_req   <= 1'b0;
        r_bus_err   <= w_expire;
      end else if (r_bus_req) begin
        r_cnt       <= r_cnt + CW'(1'b1);
      end else begin
        r_cnt       <= r_cnt;
      end
    end
  end

  // Done flags stay set while the owning stage is stalled; a fresh delivery wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata  <= 32'h0000_0000;
      r_mem_rdata <= 32'h0000_0000;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      if (w_deliver && r_state == ST_IF_BUSY) begin
        r_if_rdata <= w_ret_data;
        r_if_done  <= 1'b1;
      end else if (bif.flush || !bif.stall[1]) begin
        r_if_done  <= 1'b0;
      end else begin
        r_if_done  <= r_if_done;
      end

      if (w_deliver && r_state == ST_MEM_BUSY) begin
        r_mem_rdata <= r_bus_we ? r_mem_rdata : w_ret_data;
        r_mem_done  <= 1'b1;
      end else if (bif.flush || !bif.stall[4]) begin
        r_mem_done  <= 1'b0;
      end else begin
        r_mem_done  <= r_mem_done;
      end

      if (w_finish) begin
        r_discard <= 1'b0;
      end else if (bif.flush && r_state != ST_IDLE) begin
        r_discard <= 1'b1;
      end else begin
        r_discard <= r_discard;
      end
    end
  end

  assign bif.stallreq_if  = bif.if_ce & ~r_if_done;
  assign bif.stallreq_mem = bif.mem_ce & ~r_mem_done;
  assign bif.bus_req      = r_bus_req;
  assign bif.bus_we       = r_bus_we;
  assign bif.bus_sel      = r_bus_sel;
  assign bif.bus_addr     = r_bus_addr;
  assign bif.bus_wdata    = r_bus_wdata;
  assign bif.bus_err      = r_bus_err;
  assign bif.if_rdata     = r_if_rdata;
  assign bif.mem_rdata    = r_mem_rdata;

endmodule
